// File: rtl/restoring_div_pkg.sv
// Shared types and constants for the 8-by-4 restoring divider.
// Pure declarations: no logic, no latency, no flow control.
`timescale 1ns/1ps
package restoring_div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int STEP_CNT_W = 3;
  localparam int PR_W       = DIVISOR_W + 1;

  localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_div_if.sv
// Request/result bundle of the divider; master issues operands, slave returns results.
// Wires only: no latency; start is a pulse, with no ready signal and no queueing.
`timescale 1ns/1ps
interface restoring_div_if;
  import restoring_div_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  busy;
  logic                  done;
  logic                  div_err;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_err
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_err
  );

endinterface

// File: rtl/restoring_div_csel_sub5.sv
// 5-bit unsigned subtract a-b with carry-select upper bits; purely combinational.
// Borrow-out high means a < b. No flow control.
`timescale 1ns/1ps
module csel_sub5 (
  input  logic [4:0] a_i,
  input  logic [4:0] b_i,
  output logic [4:0] diff_o,
  output logic       borrow_o
);

  logic       br0, br1;
  logic [1:0] lo_diff;
  logic [3:0] hi_b0, hi_b1;

  // Low two bits as an explicit ripple of full subtractors.
  assign lo_diff[0] = a_i[0] ^ b_i[0];
  assign br0        = ~a_i[0] & b_i[0];
  assign lo_diff[1] = a_i[1] ^ b_i[1] ^ br0;
  assign br1        = (~a_i[1] & b_i[1]) | (~(a_i[1] ^ b_i[1]) & br0);

  // Upper three bits for both borrow-in values; bit 3 is the borrow-out.
  assign hi_b0 = {1'b0, a_i[4:2]} - {1'b0, b_i[4:2]};
  assign hi_b1 = {1'b0, a_i[4:2]} - {1'b0, b_i[4:2]} - 4'd1;

  assign diff_o   = {(br1 ? hi_b1[2:0] : hi_b0[2:0]), lo_diff};
  assign borrow_o = br1 ? hi_b1[3] : hi_b0[3];

endmodule

// File: rtl/restoring_div.sv
// Unsigned 8/4 restoring divider, one quotient bit per cycle, done 9 cycles after start.
// No backpressure: start is sampled only in IDLE and ignored otherwise; divide-by-zero finishes in 1 cycle.
`timescale 1ns/1ps
module restoring_div (
  input  logic            clk,
  input  logic            rst_n,
  restoring_div_if.slave  bus
);
  import restoring_div_pkg::*;

  state_t                state_q, state_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic [PR_W-1:0]       pr_q, pr_d;
  logic                  err_q, err_d;

  logic [PR_W-1:0]       pr_shift, pr_diff, pr_step;
  logic [DIVIDEND_W-1:0] quo_step;
  logic                  borrow, accept, div0, last_step;
  logic                  busy, done;
  logic                  unused_pr_msb;

  assign accept    = (state_q == IDLE) && bus.start;
  assign div0      = (bus.divisor == '0);
  assign last_step = (cnt_q == '1);

  assign pr_shift = {pr_q[PR_W-2:0], dvd_q[DIVIDEND_W-1]};

  csel_sub5 u_sub (
    .a_i      (pr_shift),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (pr_diff),
    .borrow_o (borrow)
  );

  // Borrow means the shifted remainder was below the divisor: restore.
  assign pr_step  = borrow ? pr_shift : pr_diff;
  assign quo_step = {quo_q[DIVIDEND_W-2:0], ~borrow};

  // The restored remainder is always below the divisor, so its MSB stays 0.
  assign unused_pr_msb = pr_q[PR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = div0 ? DONE : CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    err_d       = err_q;
    if (accept && !div0) begin
      cnt_d = '0;
      dvd_d = bus.dividend;
      dvs_d = bus.divisor;
      pr_d  = '0;
      quo_d = '0;
    end else if (accept) begin
      quotient_d  = DIV0_QUOTIENT;
      remainder_d = bus.dividend[DIVISOR_W-1:0];
      err_d       = 1'b1;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
      pr_d  = pr_step;
      quo_d = quo_step;
      if (last_step) begin
        quotient_d  = quo_step;
        remainder_d = pr_step[DIVISOR_W-1:0];
        err_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      err_q       <= err_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.div_err   = err_q;

endmodule

// File: tb/tb_restoring_div.sv
// Directed-vector bench for restoring_div: table of hand-computed results plus
// sequences for ignored start, reset mid-operation, back-to-back and a full sweep.
`timescale 1ns/1ps
module tb_restoring_div;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  restoring_div_if bus ();

  restoring_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  always @(negedge clk) begin
    if (bus.done && bus.busy) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Starts in an IDLE cycle (just after a rising edge), returns one cycle after done.
  // lat counts rising edges from the accepting edge (1) to the edge that raised done.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat,
                        output logic [7:0] q, output logic [3:0] r, output logic e,
                        output logic busy_seen);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_seen = bus.busy;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      busy_seen |= bus.busy;
    end
    q = bus.quotient;
    r = bus.remainder;
    e = bus.div_err;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int         lat, dones;
    logic [7:0] q;
    logic [3:0] r;
    logic       e, bs;

    vt[0] = '{a: 8'd100,  b: 4'd7,  q: 8'd14,  r: 4'd2,   e: 1'b0, lat: 9};
    vt[1] = '{a: 8'd255,  b: 4'd1,  q: 8'd255, r: 4'd0,   e: 1'b0, lat: 9};
    vt[2] = '{a: 8'd255,  b: 4'd15, q: 8'd17,  r: 4'd0,   e: 1'b0, lat: 9};
    vt[3] = '{a: 8'd5,    b: 4'd9,  q: 8'd0,   r: 4'd5,   e: 1'b0, lat: 9};
    vt[4] = '{a: 8'd0,    b: 4'd3,  q: 8'd0,   r: 4'd0,   e: 1'b0, lat: 9};
    vt[5] = '{a: 8'd200,  b: 4'd13, q: 8'd15,  r: 4'd5,   e: 1'b0, lat: 9};
    vt[6] = '{a: 8'h2C,   b: 4'd0,  q: 8'hFF,  r: 4'hC,   e: 1'b1, lat: 1};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    #1;
    check("reset_quotient",  bus.quotient,  0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_busy",      bus.busy,      0);
    check("reset_done",      bus.done,      0);
    check("reset_div_err",   bus.div_err,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, lat, q, r, e, bs);
      check($sformatf("vec%0d_latency", i),   lat, vt[i].lat);
      check($sformatf("vec%0d_quotient", i),  q,   vt[i].q);
      check($sformatf("vec%0d_remainder", i), r,   vt[i].r);
      check($sformatf("vec%0d_div_err", i),   e,   vt[i].e);
      check($sformatf("vec%0d_busy_seen", i), bs,  (vt[i].b != 0));
      check($sformatf("vec%0d_done_drop", i), bus.done, 0);
    end

    // Reset in CALC cycle 4 while outputs still hold the divide-by-zero result.
    bus.dividend = 8'd100;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("midcalc_busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midcalc_reset_quotient",  bus.quotient,  0);
    check("midcalc_reset_remainder", bus.remainder, 0);
    check("midcalc_reset_div_err",   bus.div_err,   0);
    check("midcalc_reset_busy",      bus.busy,      0);
    dones = 0;
    repeat (10) begin @(posedge clk); #1; dones += int'(bus.done); end
    check("midcalc_reset_no_done", dones, 0);
    rst_n = 1'b1;
    run_op(8'd255, 4'd15, lat, q, r, e, bs);
    check("post_reset_latency",   lat, 9);
    check("post_reset_quotient",  q,   17);
    check("post_reset_remainder", r,   0);

    // Start with new operands during CALC cycle 3 must be ignored.
    bus.dividend = 8'd100;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.dividend = 8'd50;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    q = '0;
    r = '0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        q = bus.quotient;
        r = bus.remainder;
      end
    end
    check("ignored_start_done_count", dones, 1);
    check("ignored_start_quotient",   q,     14);
    check("ignored_start_remainder",  r,     2);

    // Back-to-back: the second start lands in the IDLE cycle right after done.
    run_op(8'd100, 4'd7, lat, q, r, e, bs);
    check("b2b_first_quotient", q, 14);
    run_op(8'd50, 4'd5, lat, q, r, e, bs);
    check("b2b_second_latency",   lat, 9);
    check("b2b_second_quotient",  q,   10);
    check("b2b_second_remainder", r,   0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(a[7:0], b[3:0], lat, q, r, e, bs);
        check($sformatf("sweep_%0d_div_%0d", a, b), {lat[3:0], e, q, r},
              {4'd9, 1'b0, 8'(a / b), 4'(a % b)});
      end
    end

    check("done_busy_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/restoring_div.md
RESTORING_DIV -- requirements
Module: restoring_div

Interface
REQ-001 Parameter: none; widths fixed at dividend 8 bits, divisor 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend, captured when start accepted.
REQ-006 divisor  input  4  unsigned divisor, captured when start accepted.
REQ-007 quotient  output  8  registered unsigned quotient.
REQ-008 remainder  output  4  registered unsigned remainder.
REQ-009 busy  output  1  high while state is CALC.
REQ-010 done  output  1  one-cycle pulse when results valid.
REQ-011 div_err  output  1  divide-by-zero flag; valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 with divisor!=0 SHALL capture operands, clear the 5-bit partial remainder and the step counter, and go to CALC.
REQ-014 IDLE: start=1 with divisor==0 SHALL go directly to DONE with quotient=8'hFF, remainder=dividend[3:0], div_err=1.
REQ-015 CALC SHALL perform one restoring step per cycle, MSB first: pr = {pr[3:0], next dividend bit}; if pr >= {1'b0,divisor} then pr -= divisor and the quotient bit is 1, else the quotient bit is 0.
REQ-016 The compare/subtract SHALL be 5-bit unsigned; the borrow-out of the subtract SHALL decide restore (borrow=1 -> keep shifted pr).
REQ-017 CALC SHALL last exactly 8 cycles, then go to DONE; total latency from the start-accept edge to done high SHALL be 9 cycles.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 quotient/remainder/div_err SHALL update only on the DONE entry edge and hold until the next DONE.
REQ-020 start while in CALC or DONE SHALL be ignored (no queueing); operand changes after acceptance SHALL have no effect.
REQ-021 start asserted in the IDLE cycle following DONE SHALL be accepted (back-to-back operations permitted).
REQ-022 Final remainder SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for every divisor != 0.
REQ-023 busy SHALL be 0 in IDLE and DONE; done and busy SHALL never be high together.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, quotient=0, remainder=0, busy=0, done=0, div_err=0, and clear internal registers.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; first accepted start after release SHALL run normally.
REQ-026 Reset SHALL be released synchronously by the integrator; the block SHALL not require more than one cycle after release before accepting start.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, CALC, DONE), DIVIDEND_W=8, DIVISOR_W=4, STEP_CNT_W=3, and the divide-by-zero quotient constant 8'hFF.
REQ-028 One sub-module, csel_sub5, SHALL implement the 5-bit subtract as a carry-select structure (low 2 bits ripple, upper 3 bits computed for borrow-in 0 and 1 and selected), outputting difference and borrow.
REQ-029 restoring_div SHALL contain FSM, step counter, operand/quotient shift registers, and output registers; no combinational path from inputs to outputs.

Verification
REQ-030 dividend=100, divisor=7, start one cycle -> done exactly 9 cycles later, quotient=14, remainder=2, div_err=0.
REQ-031 dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=255, divisor=15 -> quotient=17, remainder=0.
REQ-032 dividend=5, divisor=9 -> quotient=0, remainder=5; dividend=0, divisor=3 -> quotient=0, remainder=0.
REQ-033 divisor=0, dividend=8'h2C -> done one cycle after accept, quotient=8'hFF, remainder=4'hC, div_err=1, busy never high.
REQ-034 start 100/7 then start 50/5 asserted on cycle 3 of CALC -> only one done, results 14/2; start 50/5 right after done -> 10/0.
REQ-035 rst_n low in CALC cycle 4 -> all outputs 0 immediately, no done; exhaustive sweep of all 256x15 nonzero pairs matches REQ-022.
